// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline stage registers.
// Latency: n/a (constants only).
// Backpressure: n/a.
package pipe_pkg;

  // Stage occupancy, derived from the main/skid slot valid bits.
  localparam logic [1:0] ST_EMPTY = 2'd0;  // main 0, skid 0
  localparam logic [1:0] ST_BUSY  = 2'd1;  // main 1, skid 0
  localparam logic [1:0] ST_FULL  = 2'd2;  // main 1, skid 1

  // All-zero encoding is sll $0,$0,0 on MIPS.
  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

  // Carried bundle widths per pipeline boundary.
  localparam int IF_ID_W  = 64;   // {PC+4, instruction}
  localparam int ID_EX_W  = 160;
  localparam int EX_MEM_W = 112;
  localparam int MEM_WB_W = 104;

endpackage

// File: rtl/pipe_slot.sv
// One data+valid register slot with load/clear; clear and reset load NOP_DATA.
// Latency: 1 cycle (posedge Clk). Backpressure: none, the owner decides load/clear.
// Ports: Clk, Reset (sync, active-high), clear, load, load_data -> vld, data.
module pipe_slot #(
  parameter int                DATA_W   = 64,
  parameter logic [DATA_W-1:0] NOP_DATA = {DATA_W{1'b0}}
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  output logic              vld,
  output logic [DATA_W-1:0] data
);

  // Clear wins over load so a flush can never leave a live beat behind.
  always_ff @(posedge Clk) begin
    if (Reset || clear) begin
      vld  <= 1'b0;
      data <= NOP_DATA;
    end else if (load) begin
      vld  <= 1'b1;
      data <= load_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with 2-entry skid buffer, flush and NOP fill.
// Latency: 1 cycle from accept to OutValid; 1 beat/cycle sustained with OutReady=1.
// Backpressure: OutReady low stalls; InReady (flop-driven) drops only when both slots hold beats.
// Ports: Clk, Reset (sync, active-high), Flush; InValid/InReady/InData upstream;
//        OutValid/OutReady/OutData downstream. OutData is NOP_DATA whenever OutValid=0.
// Option: define PIPE_STAGE_HALF_CYCLE_OUT_EN to re-register OutValid/OutData on negedge Clk.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = IF_ID_W,
  parameter logic [DATA_W-1:0] NOP_DATA = {DATA_W{1'b0}}
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              InValid,
  output logic              InReady,
  input  logic [DATA_W-1:0] InData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] OutData
);

  logic              main_vld, skid_vld;
  logic [DATA_W-1:0] main_dat, skid_dat;

  logic              main_load, main_clear, skid_load, skid_clear;
  logic [DATA_W-1:0] main_din;
  logic [1:0]        state;
  logic              accept, drain;

  // State register: the two slots themselves.
  pipe_slot #(.DATA_W(DATA_W), .NOP_DATA(NOP_DATA)) u_main (
    .Clk       (Clk),
    .Reset     (Reset),
    .clear     (main_clear),
    .load      (main_load),
    .load_data (main_din),
    .vld       (main_vld),
    .data      (main_dat)
  );

  pipe_slot #(.DATA_W(DATA_W), .NOP_DATA(NOP_DATA)) u_skid (
    .Clk       (Clk),
    .Reset     (Reset),
    .clear     (skid_clear),
    .load      (skid_load),
    .load_data (InData),
    .vld       (skid_vld),
    .data      (skid_dat)
  );

  always_comb begin
    if (skid_vld)      state = ST_FULL;
    else if (main_vld) state = ST_BUSY;
    else               state = ST_EMPTY;
  end

  // InReady comes straight off the skid valid flop; handshakes always use
  // the posedge slot state, never the optional negedge output copies.
  assign InReady = ~skid_vld;
  assign accept  = InValid & InReady;
  assign drain   = main_vld & OutReady;

  // Next-state: slot load/clear controls.
  always_comb begin
    main_load  = 1'b0;
    main_clear = 1'b0;
    main_din   = InData;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (Flush) begin
      // A concurrent drain has already been taken by the consumer; a
      // concurrent accept is swallowed by not loading it anywhere.
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: main_load = accept;
        ST_BUSY: begin
          if (accept && drain)  main_load  = 1'b1;
          else if (accept)      skid_load  = 1'b1;
          else if (drain)       main_clear = 1'b1;
        end
        ST_FULL: begin
          if (drain) begin
            main_load  = 1'b1;
            main_din   = skid_dat;
            skid_clear = 1'b1;
          end
        end
        default: begin
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  // Output stage.
`ifdef PIPE_STAGE_HALF_CYCLE_OUT_EN
  // Consumers see the posedge state half a cycle later, matching the
  // write-first-half / read-second-half register file timing.
  logic              out_vld_q;
  logic [DATA_W-1:0] out_dat_q;

  always_ff @(negedge Clk) begin
    if (Reset) begin
      out_vld_q <= 1'b0;
      out_dat_q <= NOP_DATA;
    end else begin
      out_vld_q <= main_vld;
      out_dat_q <= main_dat;
    end
  end

  assign OutValid = out_vld_q;
  assign OutData  = out_dat_q;
`else
  assign OutValid = main_vld;
  assign OutData  = main_dat;
`endif

endmodule
